fp16_alu_feeder: RTL and testbench

Issue/collect front end for the FP16 ALU. It accepts operation requests on a valid/ready stream, registers them onto the ALU input port, and tags each issue in order. Because the ALU result port has no backpressure, the feeder captures every result into an internal FIFO and returns it with its tag on a valid/ready output stream. A credit scheme guarantees the FIFO never overflows.

---
 rtl/fp16_alu_feeder_if.sv | 46 ++++
 rtl/fp16_alu_feeder.sv | 84 ++++++++
 tb/tb_fp16_alu_feeder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_alu_feeder_if.sv
// fp16_alu_feeder_if: request, ALU issue/collect and result signals of the FP16 ALU feeder
interface fp16_alu_feeder_if #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
);
    logic                    s_valid;
    logic                    s_ready;
    logic [3:0]              s_opmode;
    logic [15:0]             s_a;
    logic [15:0]             s_b;
    logic [15:0]             s_c;
    logic [TAG_W-1:0]        s_tag;
    logic                    alu_in_valid;
    logic [3:0]              alu_opmode;
    logic [15:0]             alu_a;
    logic [15:0]             alu_b;
    logic [15:0]             alu_c;
    logic [15:0]             alu_out;
    logic                    alu_out_valid;
    logic                    m_valid;
    logic                    m_ready;
    logic [15:0]             m_data;
    logic [TAG_W-1:0]        m_tag;
    logic [$clog2(DEPTH):0]  inflight;
    logic                    err;

    modport slave (
        input  s_valid, s_opmode, s_a, s_b, s_c, s_tag,
        output s_ready,
        output alu_in_valid, alu_opmode, alu_a, alu_b, alu_c,
        input  alu_out, alu_out_valid,
        output m_valid, m_data, m_tag,
        input  m_ready,
        output inflight, err
    );

    modport master (
        output s_valid, s_opmode, s_a, s_b, s_c, s_tag,
        input  s_ready,
        input  alu_in_valid, alu_opmode, alu_a, alu_b, alu_c,
        output alu_out, alu_out_valid,
        input  m_valid, m_data, m_tag,
        output m_ready,
        input  inflight, err
    );
endinterface

// File: rtl/fp16_alu_feeder.sv
// fp16_alu_feeder: tags and issues FP16 ALU requests, buffers unstallable results in a credit-protected FIFO
module fp16_alu_feeder #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input logic              clk,
    input logic              rst,
    fp16_alu_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_U = (CW + 1)'(DEPTH);

    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [15:0]      res_data [DEPTH];
    logic [TAG_W-1:0] res_tag [DEPTH];
    logic [AW-1:0]    tag_wp, tag_rp, res_wp, res_rp;
    logic [CW-1:0]    fifo_count, inflight_q;
    logic [CW:0]      used;
    logic             issue_q, err_q;
    logic [3:0]       op_q;
    logic [15:0]      a_q, b_q, c_q;
    logic             accept, take, pop;

    // Every issued request owns a FIFO slot until it is popped, so the FIFO cannot overflow.
    assign used        = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign bus.s_ready = used < DEPTH_U;
    assign accept      = bus.s_valid && bus.s_ready;
    assign take        = bus.alu_out_valid && inflight_q != '0;
    assign pop         = fifo_count != '0 && bus.m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wp     <= '0;
            tag_rp     <= '0;
            res_wp     <= '0;
            res_rp     <= '0;
            fifo_count <= '0;
            inflight_q <= '0;
            issue_q    <= 1'b0;
            err_q      <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
        end else begin
            issue_q    <= accept;
            inflight_q <= inflight_q + CW'(accept) - CW'(take);
            fifo_count <= fifo_count + CW'(take) - CW'(pop);
            if (accept) begin
                op_q   <= bus.s_opmode;
                a_q    <= bus.s_a;
                b_q    <= bus.s_b;
                c_q    <= bus.s_c;
                tag_wp <= tag_wp + 1'b1;
            end
            if (take) begin
                tag_rp <= tag_rp + 1'b1;
                res_wp <= res_wp + 1'b1;
            end
            if (pop) res_rp <= res_rp + 1'b1;
            if (bus.alu_out_valid && inflight_q == '0) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) tag_mem[tag_wp] <= bus.s_tag;
        if (take) begin
            res_data[res_wp] <= bus.alu_out;
            res_tag[res_wp]  <= tag_mem[tag_rp];
        end
    end

    assign bus.alu_in_valid = issue_q;
    assign bus.alu_opmode   = op_q;
    assign bus.alu_a        = a_q;
    assign bus.alu_b        = b_q;
    assign bus.alu_c        = c_q;
    assign bus.m_valid      = fifo_count != '0;
    assign bus.m_data       = bus.m_valid ? res_data[res_rp] : '0;
    assign bus.m_tag        = bus.m_valid ? res_tag[res_rp] : '0;
    assign bus.inflight     = inflight_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_fp16_alu_feeder.sv
// tb_fp16_alu_feeder: random and directed stimulus against a queue-based model of the feeder
module tb_fp16_alu_feeder;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [15:0]      d;
        logic [TAG_W-1:0] t;
    } res_t;

    typedef struct {
        int          due;
        logic [15:0] v;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp16_alu_feeder_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
    fp16_alu_feeder #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ALU environment: in-order, variable latency, never stalls
    bit    fixed_alu = 0;
    bit    spur = 0;
    int    cyc = 0;
    pend_t pend[$];
    int    last_due = 0;
    int    lat, due;
    logic  r;

    initial begin
        bus.alu_out_valid = 1'b0;
        bus.alu_out = '0;
        forever begin
            @(posedge clk);
            r = rst;
            #2;
            cyc++;
            if (r) begin
                pend.delete();
                last_due = 0;
            end else if (bus.alu_in_valid) begin
                lat = fixed_alu ? 3 : int'($urandom_range(1, 4));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{due, fixed_alu ? 16'h4700 :
                               (bus.alu_a + bus.alu_b) ^ bus.alu_c ^ {12'h0, bus.alu_opmode}});
            end
            bus.alu_out_valid = 1'b0;
            bus.alu_out = 16'($urandom);
            if (spur) bus.alu_out_valid = 1'b1;
            else if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.alu_out_valid = 1'b1;
                bus.alu_out = pend[0].v;
                void'(pend.pop_front());
            end
        end
    end

    // Behavioural model: tags waiting for results, results waiting for the consumer
    int               inf_m = 0;
    bit               err_m = 0, av_m = 0, armed = 0, acc_m, tk_m;
    logic [3:0]       op_m = '0;
    logic [15:0]      a_m = '0, b_m = '0, c_m = '0;
    logic [TAG_W-1:0] tag_q[$];
    res_t             fifo_q[$];
    res_t             tmp;

    always @(negedge clk) begin
        if (armed) begin
            chk("s_ready", bus.s_ready, 32'(fifo_q.size() + inf_m < DEPTH));
            chk("alu_in_valid", bus.alu_in_valid, 32'(av_m));
            chk("alu_opmode", bus.alu_opmode, op_m);
            chk("alu_a", bus.alu_a, a_m);
            chk("alu_b", bus.alu_b, b_m);
            chk("alu_c", bus.alu_c, c_m);
            chk("m_valid", bus.m_valid, 32'(fifo_q.size() > 0));
            if (fifo_q.size() > 0) begin
                chk("m_data", bus.m_data, fifo_q[0].d);
                chk("m_tag", bus.m_tag, fifo_q[0].t);
            end
            chk("inflight", bus.inflight, inf_m);
            chk("err", bus.err, 32'(err_m));
        end
        if (rst) begin
            tag_q.delete();
            fifo_q.delete();
            inf_m = 0;
            err_m = 0;
            av_m = 0;
            op_m = '0;
            a_m = '0;
            b_m = '0;
            c_m = '0;
            armed = 1;
        end else begin
            acc_m = bus.s_valid && (fifo_q.size() + inf_m < DEPTH);
            tk_m = bus.alu_out_valid && inf_m > 0;
            if (fifo_q.size() > 0 && bus.m_ready) void'(fifo_q.pop_front());
            if (tk_m) begin
                tmp.d = bus.alu_out;
                tmp.t = tag_q.pop_front();
                fifo_q.push_back(tmp);
                inf_m--;
            end else if (bus.alu_out_valid) err_m = 1;
            av_m = acc_m;
            if (acc_m) begin
                op_m = bus.s_opmode;
                a_m = bus.s_a;
                b_m = bus.s_b;
                c_m = bus.s_c;
                tag_q.push_back(bus.s_tag);
                inf_m++;
            end
        end
    end

    logic [TAG_W-1:0] got_tags[$];
    int n, ic, acc;

    task automatic step();
        if (bus.m_valid && bus.m_ready) got_tags.push_back(bus.m_tag);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(input logic [TAG_W-1:0] tag);
        bus.s_opmode = 4'($urandom);
        bus.s_a = 16'($urandom);
        bus.s_b = 16'($urandom);
        bus.s_c = 16'($urandom);
        bus.s_tag = tag;
    endtask

    task automatic drain(input string name);
        bus.m_ready = 1'b1;
        n = 0;
        while ((bus.inflight != 0 || bus.m_valid) && n < 200) begin
            step();
            n++;
        end
        chk(name, 32'(n < 200), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        rand_req('0);
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_alu_in_valid", bus.alu_in_valid, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_tag", bus.m_tag, 0);
        chk("rst_inflight", bus.inflight, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_alu_a", bus.alu_a, 0);

        fixed_alu = 1;
        bus.s_valid = 1'b1;
        bus.s_opmode = 4'h0;
        bus.s_a = 16'h4000;
        bus.s_b = 16'h4200;
        bus.s_c = 16'h3C00;
        bus.s_tag = 4'd5;
        step();
        bus.s_valid = 1'b0;
        chk("single_issue", bus.alu_in_valid, 1);
        chk("single_alu_b", bus.alu_b, 16'h4200);
        chk("single_inflight1", bus.inflight, 1);
        step();
        chk("single_pulse_end", bus.alu_in_valid, 0);
        n = 0;
        while (!bus.m_valid && n < 20) begin
            step();
            n++;
        end
        chk("single_latency", n, 3);
        chk("single_m_data", bus.m_data, 16'h4700);
        chk("single_m_tag", bus.m_tag, 5);
        chk("single_inflight0", bus.inflight, 0);
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("single_popped", bus.m_valid, 0);
        fixed_alu = 0;

        got_tags.delete();
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        ic = 0;
        for (int i = 0; i < 20; i++) begin
            rand_req(TAG_W'(i % 16));
            chk("stream_ready", bus.s_ready, 1);
            step();
            if (bus.alu_in_valid) ic++;
        end
        bus.s_valid = 1'b0;
        chk("stream_issues", ic, 20);
        drain("stream_drain");
        chk("stream_count", got_tags.size(), 20);
        for (int i = 0; i < 20 && i < got_tags.size(); i++) chk("stream_tag", got_tags[i], i % 16);
        chk("stream_err", bus.err, 0);

        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            rand_req(TAG_W'(i));
            if (bus.s_ready) acc++;
            step();
        end
        bus.s_valid = 1'b0;
        chk("bp_accepts", acc, 8);
        chk("bp_stalled", bus.s_ready, 0);
        n = 0;
        while (bus.inflight != 0 && n < 30) begin
            step();
            n++;
        end
        chk("bp_all_returned", bus.inflight, 0);
        chk("bp_still_stalled", bus.s_ready, 0);
        got_tags.delete();
        bus.m_ready = 1'b1;
        step();
        bus.m_ready = 1'b0;
        chk("bp_credit_back", bus.s_ready, 1);
        drain("bp_drain");
        chk("bp_count", got_tags.size(), 8);
        for (int i = 0; i < 8 && i < got_tags.size(); i++) chk("bp_tag", got_tags[i], i);

        for (int i = 0; i < 800; i++) begin
            bus.s_valid = ($urandom % 3) != 0;
            rand_req(TAG_W'($urandom));
            bus.m_ready = ((i / 40) % 3 == 2) ? 1'b0 : (($urandom % 4) != 0);
            step();
        end
        bus.s_valid = 1'b0;
        drain("rand_drain");
        chk("rand_err", bus.err, 0);

        bus.m_ready = 1'b0;
        spur = 1;
        step();
        spur = 0;
        step();
        chk("spur_err", bus.err, 1);
        chk("spur_m_valid", bus.m_valid, 0);
        chk("spur_inflight", bus.inflight, 0);
        repeat (5) step();
        chk("spur_sticky", bus.err, 1);

        fixed_alu = 1;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_req(TAG_W'(i));
            step();
        end
        bus.s_valid = 1'b0;
        n = 0;
        while (!(bus.inflight == 3 && fifo_q.size() == 2) && n < 20) begin
            step();
            n++;
        end
        chk("mid_inflight3", bus.inflight, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        fixed_alu = 0;
        chk("mid_m_valid", bus.m_valid, 0);
        chk("mid_inflight", bus.inflight, 0);
        chk("mid_alu_in_valid", bus.alu_in_valid, 0);
        chk("mid_s_ready", bus.s_ready, 1);
        chk("mid_err", bus.err, 0);
        repeat (8) step();
        chk("mid_no_stale", bus.err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
